// File: rtl/ext_data_memory.sv
// Line-wide (256-bit) external data memory model with a fixed multi-cycle access latency.
// One request is accepted at a time from IDLE. Completion is a single-cycle ack pulse.
module ext_data_memory #(
  parameter int unsigned MEM_LINES = 512,
  parameter int unsigned LATENCY   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         cs_i,
  input  logic         we_i,
  output logic [255:0] data_o,
  output logic         ack_o
);

  localparam int unsigned IDX_W = $clog2(MEM_LINES);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   line_q;
  logic [255:0]       wdata_q;
  logic               we_q;
  logic               accept_c;
  logic               done_c;
  logic [255:0]       mem [MEM_LINES];

  // Offset and out-of-range bits are ignored, so addresses wrap modulo MEM_LINES.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (cs_i) state_next = BUSY;
      BUSY:    if (cnt == CNT_W'(LATENCY - 1)) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control decodes
  always_comb begin
    accept_c = 1'b0;
    done_c   = 1'b0;
    if (state == IDLE) accept_c = cs_i;
    if (state == BUSY) done_c = (cnt == CNT_W'(LATENCY - 1));
  end

  // Request latch, latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      line_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ack_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      ack_o <= done_c;
      if (accept_c) begin
        cnt     <= '0;
        line_q  <= addr_i[5 +: IDX_W];
        wdata_q <= data_i;
        we_q    <= we_i;
      end else if ((state == BUSY) && !done_c) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (done_c && !we_q) data_o <= mem[line_q];
    end
  end

  // Storage array is deliberately not reset; a reset mid-access suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && done_c && we_q) mem[line_q] <= wdata_q;
  end

endmodule

// File: tb/tb_ext_data_memory.sv
// Scoreboard bench for ext_data_memory: expectations are queued at request time
// and compared (data and latency) when the ack pulse appears.
module tb_ext_data_memory;

  localparam int unsigned LAT   = 10;
  localparam int unsigned LINES = 512;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  addr_i = '0;
  logic [255:0] data_i = '0;
  logic         cs_i = 1'b0;
  logic         we_i = 1'b0;
  logic [255:0] data_o;
  logic         ack_o;

  ext_data_memory #(.MEM_LINES(LINES), .LATENCY(LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr_i (addr_i),
    .data_i (data_i),
    .cs_i   (cs_i),
    .we_i   (we_i),
    .data_o (data_o),
    .ack_o  (ack_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  acc;
    logic [255:0] data;
  } exp_t;

  exp_t         sb [$];
  logic [255:0] mdl_mem [LINES];
  logic [255:0] mdl_dout = '0;
  int unsigned  cyc = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  logic         prev_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack_o === 1'b1) begin
      check("ack_width", 256'(prev_ack), 256'(0));
      if (sb.size() == 0) begin
        check("spurious_ack", 256'(ack_o), 256'(0));
      end else begin
        exp_t it;
        it = sb.pop_front();
        check("latency", 256'(cyc - it.acc), 256'(LAT));
        check("data_o", data_o, it.data);
      end
    end
    prev_ack = ack_o;
  end

  // Drive one request; hold = extra cycles cs_i stays high before inputs are scrambled.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [255:0] data,
                       input int hold);
    exp_t        it;
    logic [31:0] a;
    a = addr;
    @(negedge clk);
    cs_i = 1'b1; we_i = we; addr_i = addr; data_i = data;
    if (we) mdl_mem[a[13:5]] = data;
    else    mdl_dout = mdl_mem[a[13:5]];
    it.acc  = cyc + 1;
    it.data = mdl_dout;
    sb.push_back(it);
    repeat (hold + 1) @(negedge clk);
    cs_i = 1'b0; we_i = ~we; addr_i = addr + 32'h20; data_i = ~data;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3 * LAT + 10; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("drain", 256'(sb.size()), 256'(0));
    sb.delete();
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [255:0] data);
    issue(we, addr, data, 0);
    wait_drain();
  endtask

  task automatic idle_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_dout = '0;
    check("reset_ack", 256'(ack_o), 256'(0));
    check("reset_dout", data_o, 256'(0));
  endtask

  logic [255:0] pat_a, pat_a3, pat_b, pat_c, pat_d, pat_e, old3;

  initial begin
    pat_a  = {8{32'hA5A5_0001}};
    pat_a3 = {8{32'h3333_C0DE}};
    pat_b  = {8{32'hBBBB_0B0B}};
    pat_c  = {4{64'h0123_4567_89AB_CDEF}};
    pat_d  = {8{32'hD00D_F00D}};
    pat_e  = {8{32'hEEEE_1234}};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("init_ack", 256'(ack_o), 256'(0));
    check("init_dout", data_o, 256'(0));

    // Known contents for lines read later
    xact(1'b1, 32'h0000_0020, 256'(0));
    xact(1'b1, 32'h0000_0060, pat_a3);
    xact(1'b1, 32'h0000_00C0, pat_e);

    // Read after reset
    idle_reset();
    xact(1'b0, 32'h0000_0020, 256'(0));

    // Write then read back; offset bits ignored
    xact(1'b1, 32'h0000_0040, 256'(32'hDEAD_BEEF));
    xact(1'b0, 32'h0000_005F, 256'(0));

    // Address wrap at both ends of the array
    xact(1'b1, 32'h0000_4000, pat_a);
    xact(1'b0, 32'h0000_0000, 256'(0));
    xact(1'b1, 32'hFFFF_FFE0, pat_c);
    xact(1'b0, 32'h0000_3FE0, 256'(0));

    // Inputs scrambled and cs_i dropped at E0+3 must not disturb the access
    issue(1'b1, 32'h0000_00A0, pat_d, 2);
    wait_drain();
    xact(1'b0, 32'h0000_00A0, 256'(0));
    xact(1'b0, 32'h0000_00C0, 256'(0));

    // Reset at E0+5 of a write: no commit, no ack
    old3 = mdl_mem[3];
    issue(1'b1, 32'h0000_0060, pat_b, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    mdl_mem[3] = old3;
    mdl_dout = '0;
    check("midrst_ack", 256'(ack_o), 256'(0));
    check("midrst_dout", data_o, 256'(0));
    repeat (LAT + 4) @(negedge clk);
    xact(1'b0, 32'h0000_0060, 256'(0));

    // Back-to-back with cs_i held high: acks every LAT+2 cycles
    @(negedge clk);
    cs_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0040;
    mdl_dout = mdl_mem[2];
    for (int k = 0; k < 3; k++) begin
      exp_t it;
      it.acc  = cyc + 1 + k * (LAT + 2);
      it.data = mdl_dout;
      sb.push_back(it);
    end
    repeat (26) @(negedge clk);
    cs_i = 1'b0;
    wait_drain();

    // Reset wins over a simultaneous request
    @(negedge clk);
    rst = 1'b1; cs_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0040; data_i = pat_b;
    @(negedge clk);
    rst = 1'b0; cs_i = 1'b0;
    mdl_dout = '0;
    repeat (LAT + 4) @(negedge clk);
    check("rst_prio_ack", 256'(ack_o), 256'(0));
    xact(1'b0, 32'h0000_0040, 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
